// File: rtl/trace_pkg.sv
// Shared types for the instruction-trace capture unit.
// Holds the core word types, the capture mode and controller state
// encodings, the packed trace entry layout and a mode decode helper.
package trace_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] instr_t;
  typedef logic [31:0] data_t;

  // Stamp field width inside an entry; the stamp counter may be narrower
  // (zero-extended) but not wider.
  localparam int STAMP_MAX_W = 32;

  typedef enum logic [1:0] {
    TM_FREE    = 2'd0,
    TM_ONESHOT = 2'd1,
    TM_TRIGGER = 2'd2
  } trace_mode_e;

  typedef enum logic [2:0] {
    TS_IDLE    = 3'd0,
    TS_CAPTURE = 3'd1,
    TS_POST    = 3'd2,
    TS_DONE    = 3'd3,
    TS_DRAIN   = 3'd4
  } trace_state_e;

  typedef struct packed {
    logic [STAMP_MAX_W-1:0] stamp;
    addr_t                  pc;
    instr_t                 instr;
    logic [4:0]             fsm_state;
    logic                   reg_write;
    logic [4:0]             rd;
    data_t                  result;
  } trace_entry_t;

  // The reserved encoding 3 behaves as free-running capture.
  function automatic trace_mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return TM_ONESHOT;
      2'd2:    return TM_TRIGGER;
      default: return TM_FREE;
    endcase
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: one write port, one read port with a
// registered output. rdata only changes on a cycle with re asserted.
// Ports: clk; we/waddr/wdata write port; re/raddr/rdata read port.
module trace_ram
  import trace_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  trace_entry_t             wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output trace_entry_t             rdata
);

  trace_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/trace_buffer.sv
// Instruction-trace capture unit: records qualified core samples into a
// circular buffer (free-running, one-shot or PC-triggered window) and
// drains them oldest-first over a valid/ready stream.
// Ports: clk, reset (sync, active-high); arm/mode/trig_pc/stop capture
// control; sample_valid + core sample fields; state/count/wrapped/
// triggered status; drain_req, out_valid/out_ready/out_entry/out_last
// readout stream.
module trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int POST_TRIG = 32,
  parameter int STAMP_W   = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arm,
  input  logic [1:0]               mode,
  input  addr_t                    trig_pc,
  input  logic                     stop,
  input  logic                     sample_valid,
  input  addr_t                    pc_cur,
  input  instr_t                   instruction,
  input  logic [4:0]               fsm_state,
  input  logic                     reg_write,
  input  logic [4:0]               rd,
  input  data_t                    result,
  output logic [2:0]               state,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     wrapped,
  output logic                     triggered,
  input  logic                     drain_req,
  output logic                     out_valid,
  input  logic                     out_ready,
  output trace_entry_t             out_entry,
  output logic                     out_last
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL      = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] POST_INIT = CNT_W'(POST_TRIG - 1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  trace_state_e       state_q, state_d;
  trace_mode_e        mode_q;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   cnt_q, post_cnt, to_issue;
  logic [STAMP_W-1:0] stamp;
  logic               wrapped_q, triggered_q;
  logic               capturing, wr_en, full, trig_hit, last_post, oneshot_fill;
  logic               rd_en, rd_pend, pf_valid, out_valid_q, pop;
  logic [1:0]         occ;
  trace_entry_t       wr_entry, rd_data, pf_entry, out_entry_q;

  assign capturing    = (state_q == TS_CAPTURE) || (state_q == TS_POST);
  // A sample coinciding with arm is dropped: the buffer is being cleared.
  assign wr_en        = capturing && sample_valid && !arm;
  assign full         = (cnt_q == FULL);
  assign trig_hit     = wr_en && (state_q == TS_CAPTURE) && (mode_q == TM_TRIGGER) &&
                        (pc_cur == trig_pc);
  assign last_post    = wr_en && (state_q == TS_POST) && (post_cnt == CNT_ONE);
  assign oneshot_fill = wr_en && (mode_q == TM_ONESHOT) && (cnt_q == FULL - CNT_ONE);

  // Readout occupancy: output register + prefetch register + RAM read in flight.
  assign pop      = out_valid_q && out_ready;
  assign occ      = {1'b0, out_valid_q} + {1'b0, pf_valid} + {1'b0, rd_pend};
  assign to_issue = cnt_q - CNT_W'(occ);

  always_comb begin
    wr_entry           = '0;
    wr_entry.stamp     = STAMP_MAX_W'(stamp);
    wr_entry.pc        = pc_cur;
    wr_entry.instr     = instruction;
    wr_entry.fsm_state = fsm_state;
    wr_entry.reg_write = reg_write;
    wr_entry.rd        = rd;
    wr_entry.result    = result;
  end

  trace_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .re    (rd_en),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // Controller state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= TS_IDLE;
    else       state_q <= state_d;
  end

  // Controller next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      TS_IDLE: if (arm) state_d = TS_CAPTURE;
      TS_CAPTURE: begin
        if (arm)               state_d = TS_CAPTURE;
        else if (stop)         state_d = TS_DONE;
        else if (trig_hit)     state_d = (POST_TRIG == 1) ? TS_DONE : TS_POST;
        else if (oneshot_fill) state_d = TS_DONE;
      end
      TS_POST: begin
        if (arm)                    state_d = TS_CAPTURE;
        else if (stop || last_post) state_d = TS_DONE;
      end
      TS_DONE: begin
        if (arm)            state_d = TS_CAPTURE;
        else if (drain_req) state_d = TS_DRAIN;
      end
      TS_DRAIN: begin
        if ((cnt_q == '0) || (pop && cnt_q == CNT_ONE)) state_d = TS_IDLE;
      end
      default: state_d = TS_IDLE;
    endcase
  end

  // Controller outputs. The first RAM read is issued on the drain_req
  // cycle so data reaches the output register two cycles later; after
  // that a read is issued whenever the two-deep output stage will have room.
  always_comb begin
    state    = state_q;
    out_last = out_valid_q && (cnt_q == CNT_ONE);
    rd_en    = 1'b0;
    if (state_q == TS_DONE && drain_req && !arm && cnt_q != '0)
      rd_en = 1'b1;
    else if (state_q == TS_DRAIN && to_issue != '0 && (occ - {1'b0, pop}) < 2'd2)
      rd_en = 1'b1;
  end

  // Capture bookkeeping: pointers, fill count, status flags, stamp
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt_q       <= '0;
      post_cnt    <= '0;
      wrapped_q   <= 1'b0;
      triggered_q <= 1'b0;
      mode_q      <= TM_FREE;
      stamp       <= '0;
    end else begin
      stamp <= stamp + STAMP_W'(1);
      if (arm && state_q != TS_DRAIN) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        cnt_q       <= '0;
        post_cnt    <= '0;
        wrapped_q   <= 1'b0;
        triggered_q <= 1'b0;
        mode_q      <= decode_mode(mode);
      end else begin
        if (wr_en) begin
          wr_ptr <= wr_ptr + PTR_ONE;
          if (full) begin
            // Overwrite the oldest entry; the read pointer follows.
            rd_ptr    <= rd_ptr + PTR_ONE;
            wrapped_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        if (trig_hit) begin
          triggered_q <= 1'b1;
          post_cnt    <= POST_INIT;
        end else if (wr_en && state_q == TS_POST) begin
          post_cnt <= post_cnt - CNT_ONE;
        end
        if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
        if (pop)   cnt_q  <= cnt_q - CNT_ONE;
      end
    end
  end

  // Readout stage: output register with a one-entry prefetch behind it
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend     <= 1'b0;
      pf_valid    <= 1'b0;
      out_valid_q <= 1'b0;
      out_entry_q <= '0;
    end else begin
      rd_pend <= rd_en;
      if (!out_valid_q || pop) begin
        if (pf_valid) begin
          out_valid_q <= 1'b1;
          out_entry_q <= pf_entry;
          pf_valid    <= rd_pend;
        end else if (rd_pend) begin
          out_valid_q <= 1'b1;
          out_entry_q <= rd_data;
        end else begin
          out_valid_q <= 1'b0;
        end
      end else if (rd_pend) begin
        pf_valid <= 1'b1;
      end
    end
  end

  // Whenever fresh RAM data is not routed straight to the output it is
  // parked here; the occupancy check guarantees the slot is free.
  always_ff @(posedge clk) begin
    if (rd_pend) pf_entry <= rd_data;
  end

  assign count     = cnt_q;
  assign wrapped   = wrapped_q;
  assign triggered = triggered_q;
  assign out_valid = out_valid_q;
  assign out_entry = out_entry_q;

endmodule

// File: tb/tb_trace_buffer.sv
// Directed bench for trace_buffer: a DEPTH=4 instance exercises one-shot
// and free-running capture, a DEPTH=8/POST_TRIG=3 instance exercises the
// trigger window, restart, empty drain and reset during readout.
module tb_trace_buffer;
  import trace_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        arm = 1'b0, stop = 1'b0, sample_valid = 1'b0, reg_write = 1'b0;
  logic        out_ready = 1'b0, drain_req4 = 1'b0, drain_req8 = 1'b0;
  logic [1:0]  mode = 2'd0;
  addr_t       trig_pc = 32'h20;
  addr_t       pc_cur = '0;
  instr_t      instruction = '0;
  data_t       result = '0;
  logic [4:0]  fsm_state = '0, rd = '0;

  logic [2:0]  state4, state8;
  logic [2:0]  count4;
  logic [3:0]  count8;
  logic        wrapped4, wrapped8, trig4, trig8, ov4, ov8, last4, last8;
  trace_entry_t oe4, oe8;

  logic         use8 = 1'b0;
  logic         d_valid, d_last;
  logic [2:0]   d_state;
  logic [3:0]   d_count;
  trace_entry_t d_entry;

  int n_checks = 0;
  int n_fail   = 0;

  trace_buffer #(.DEPTH(4), .POST_TRIG(2), .STAMP_W(32)) dut4 (
    .clk(clk), .reset(reset), .arm(arm), .mode(mode), .trig_pc(trig_pc), .stop(stop),
    .sample_valid(sample_valid), .pc_cur(pc_cur), .instruction(instruction),
    .fsm_state(fsm_state), .reg_write(reg_write), .rd(rd), .result(result),
    .state(state4), .count(count4), .wrapped(wrapped4), .triggered(trig4),
    .drain_req(drain_req4), .out_valid(ov4), .out_ready(out_ready),
    .out_entry(oe4), .out_last(last4));

  trace_buffer #(.DEPTH(8), .POST_TRIG(3), .STAMP_W(32)) dut8 (
    .clk(clk), .reset(reset), .arm(arm), .mode(mode), .trig_pc(trig_pc), .stop(stop),
    .sample_valid(sample_valid), .pc_cur(pc_cur), .instruction(instruction),
    .fsm_state(fsm_state), .reg_write(reg_write), .rd(rd), .result(result),
    .state(state8), .count(count8), .wrapped(wrapped8), .triggered(trig8),
    .drain_req(drain_req8), .out_valid(ov8), .out_ready(out_ready),
    .out_entry(oe8), .out_last(last8));

  assign d_valid = use8 ? ov8 : ov4;
  assign d_last  = use8 ? last8 : last4;
  assign d_state = use8 ? state8 : state4;
  assign d_count = use8 ? count8 : {1'b0, count4};
  assign d_entry = use8 ? oe8 : oe4;

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put_sample(input logic [31:0] pc);
    sample_valid = 1'b1;
    pc_cur       = pc;
    instruction  = pc ^ 32'hA5A5_0000;
    fsm_state    = pc[6:2];
    reg_write    = pc[2];
    rd           = pc[6:2];
    result       = pc + 32'h100;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic pulse_arm(input logic [1:0] m);
    mode = m;
    arm  = 1'b1;
    tick();
    arm  = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  // Drain one instance and compare against an arithmetic PC sequence.
  task automatic drain_check(input string tag, input logic big, input logic toggle,
                             input int n, input logic [31:0] base);
    logic [31:0]  got_pc [16];
    logic [31:0]  got_st [16];
    logic         got_lst [16];
    int           got_n;
    int           k;
    logic         held;
    logic         done;
    logic [3:0]   rdy_pat;
    trace_entry_t held_e;
    got_n   = 0;
    k       = 0;
    held    = 1'b0;
    done    = 1'b0;
    rdy_pat = 4'b1001;
    held_e  = '0;
    use8      = big;
    out_ready = 1'b0;
    if (big) drain_req8 = 1'b1;
    else     drain_req4 = 1'b1;
    tick();
    drain_req4 = 1'b0;
    drain_req8 = 1'b0;
    chk({tag, " valid_1cyc"}, d_valid, 1'b0);
    tick();
    chk({tag, " valid_2cyc"}, d_valid, 1'b1);
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      if (held) chk({tag, " stall_hold"}, (d_valid && d_entry == held_e), 1'b1);
      out_ready = toggle ? rdy_pat[k % 4] : 1'b1;
      k++;
      if (d_valid && out_ready && got_n < 16) begin
        got_pc[got_n]  = d_entry.pc;
        got_st[got_n]  = d_entry.stamp;
        got_lst[got_n] = d_last;
        chk({tag, " result"}, d_entry.result, d_entry.pc + 32'h100);
        got_n++;
        if (d_last) done = 1'b1;
      end
      held   = d_valid && !out_ready;
      held_e = d_entry;
      tick();
    end
    out_ready = 1'b0;
    chk({tag, " n_entries"}, got_n, n);
    for (int i = 0; i < n && i < got_n; i++) begin
      chk($sformatf("%s pc[%0d]", tag, i), got_pc[i], base + 32'(4 * i));
      chk($sformatf("%s last[%0d]", tag, i), got_lst[i], (i == n - 1));
      if (i > 0) chk($sformatf("%s stamp_inc[%0d]", tag, i), (got_st[i] > got_st[i-1]), 1'b1);
    end
    chk({tag, " end_state"}, d_state, 3'd0);
    chk({tag, " end_valid"}, d_valid, 1'b0);
    chk({tag, " end_count"}, d_count, 4'd0);
  endtask

  initial begin
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    // Reset state
    chk("rst state", state4, 3'd0);
    chk("rst count", count4, 3'd0);
    chk("rst wrapped", wrapped4, 1'b0);
    chk("rst triggered", trig4, 1'b0);
    chk("rst out_valid", ov4, 1'b0);
    chk("rst out_last", last4, 1'b0);
    chk("rst out_entry", (oe4 === '0), 1'b1);
    chk("rst state8", state8, 3'd0);

    // Samples in IDLE are ignored
    put_sample(32'h100);
    chk("idle ignore", count4, 3'd0);

    // ONESHOT on DEPTH=4: stops after the fourth sample
    pulse_arm(2'd1);
    chk("oneshot capture", state4, 3'd1);
    for (int i = 0; i < 6; i++) begin
      put_sample(32'(4 * i));
      if (i == 3) begin
        chk("oneshot done", state4, 3'd3);
        chk("oneshot count", count4, 3'd4);
      end
    end
    chk("oneshot count_hold", count4, 3'd4);
    chk("oneshot wrapped", wrapped4, 1'b0);
    drain_check("oneshot", 1'b0, 1'b0, 4, 32'h00);

    // FREE on DEPTH=4: six samples then stop, oldest two overwritten
    pulse_arm(2'd0);
    for (int i = 0; i < 6; i++) put_sample(32'(4 * i));
    pulse_stop();
    chk("free done", state4, 3'd3);
    chk("free wrapped", wrapped4, 1'b1);
    chk("free count", count4, 3'd4);
    drain_check("free", 1'b0, 1'b0, 4, 32'h08);

    // TRIGGER on DEPTH=8, POST_TRIG=3, trig_pc=0x20
    pulse_arm(2'd2);
    for (int i = 0; i <= 16; i++) begin
      put_sample(32'(4 * i));
      if (i == 8) begin
        chk("trig post", state8, 3'd2);
        chk("trig flag", trig8, 1'b1);
      end
      if (i == 10) chk("trig done", state8, 3'd3);
    end
    chk("trig count", count8, 4'd8);
    chk("trig wrapped", wrapped8, 1'b1);
    drain_check("trigger", 1'b1, 1'b1, 8, 32'h0C);

    // arm during POST restarts capture; empty drain returns to IDLE
    use8 = 1'b1;
    pulse_arm(2'd2);
    put_sample(32'h1C);
    put_sample(32'h20);
    chk("rearm pre_post", state8, 3'd2);
    pulse_arm(2'd2);
    chk("rearm count", count8, 4'd0);
    chk("rearm triggered", trig8, 1'b0);
    chk("rearm state", state8, 3'd1);
    pulse_stop();
    chk("empty done", state8, 3'd3);
    drain_req8 = 1'b1;
    tick();
    drain_req8 = 1'b0;
    chk("empty drain state", state8, 3'd4);
    chk("empty drain valid", ov8, 1'b0);
    tick();
    chk("empty idle state", state8, 3'd0);
    chk("empty idle valid", ov8, 1'b0);

    // reset while draining discards everything
    pulse_arm(2'd0);
    put_sample(32'h40);
    put_sample(32'h44);
    put_sample(32'h48);
    pulse_stop();
    drain_req8 = 1'b1;
    tick();
    drain_req8 = 1'b0;
    tick();
    chk("mid_drain valid", ov8, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("drain_rst state", state8, 3'd0);
    chk("drain_rst valid", ov8, 1'b0);
    chk("drain_rst count", count8, 4'd0);
    chk("drain_rst last", last8, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
